// File: rtl/maxpool_result_reader.sv
// Purpose : reads the pooled feature map back out of its M10K buffer in raster
//           order and streams it as (index, element) pairs to the dense layer.
// Latency : run -> first vec_valid_out in 4 cycles; one element per cycle after.
// Backpressure: reads are credit-limited so in-flight reads plus FIFO entries
//           never exceed FIFO_DEPTH; vec_ready_in low stalls issue, never drops.
// Ports   : clk/reset (sync, active high); run + base_addr_in start a frame;
//           read_address_out/data_in form the M10K read port; vec_* is the
//           valid/ready output stream; busy_out/done_out report frame status.
module maxpool_result_reader #(
  parameter int DATA_WIDTH   = 27,
  parameter int ADDR_WIDTH   = 10,
  parameter int LAYER_WIDTH  = 10,
  parameter int LAYER_HEIGHT = 20,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [ADDR_WIDTH-1:0]   base_addr_in,
  output logic [ADDR_WIDTH-1:0]   read_address_out,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   vec_data_out,
  output logic [$clog2((LAYER_WIDTH/2)*(LAYER_HEIGHT/2))-1:0] vec_index_out,
  output logic                    vec_valid_out,
  input  logic                    vec_ready_in,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int VEC_LEN = (LAYER_WIDTH/2)*(LAYER_HEIGHT/2);
  localparam int IDX_W   = $clog2(VEC_LEN);
  localparam int CNT_W   = $clog2(VEC_LEN + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        xfer_cnt;

  // Read-tag pipe: one slot per cycle of M10K latency.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [IDX_W-1:0]        pipe_idx [READ_LATENCY];

  // Skid FIFO holding (index, data) pairs.
  logic [DATA_WIDTH-1:0]   fifo_dat [FIFO_DEPTH];
  logic [IDX_W-1:0]        fifo_idx [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]       fifo_cnt;

  int                      in_flight;
  logic                    credit_ok;
  logic                    issue;
  logic                    capture;
  logic                    pop;
  logic                    last_issue;
  logic                    last_xfer;
  logic                    run_accept;

  always_comb begin
    in_flight = 0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      in_flight = in_flight + int'(pipe_vld[k]);
    end
  end

  // Credits count reads still in the pipe as already occupying the FIFO,
  // which is what guarantees the FIFO can never overflow.
  assign credit_ok  = (in_flight + int'(fifo_cnt)) < FIFO_DEPTH;
  assign issue      = (state == S_READ) && credit_ok;
  assign capture    = pipe_vld[READ_LATENCY-1];
  assign pop        = vec_valid_out && vec_ready_in;
  assign last_issue = issue && (issue_cnt == CNT_W'(VEC_LEN - 1));
  assign last_xfer  = pop && (xfer_cnt == CNT_W'(VEC_LEN - 1));
  assign run_accept = (state == S_IDLE) && run;

  assign vec_valid_out = (fifo_cnt != '0);
  // Masked when empty so the stream reads as zero after reset and between frames.
  assign vec_data_out  = vec_valid_out ? fifo_dat[rd_ptr] : '0;
  assign vec_index_out = vec_valid_out ? fifo_idx[rd_ptr] : '0;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_READ;
      end
      S_READ: begin
        busy_out = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy_out = 1'b1;
        if (last_xfer) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy_out  = 1'b1;
        done_out  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- control / counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q           <= '0;
      issue_cnt        <= '0;
      xfer_cnt         <= '0;
      read_address_out <= '0;
      pipe_vld         <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
    end else begin
      if (run_accept) begin
        base_q    <= base_addr_in;
        issue_cnt <= '0;
        xfer_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   xfer_cnt  <= xfer_cnt + 1'b1;
      end

      // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
      if (issue) read_address_out <= base_q + ADDR_WIDTH'(issue_cnt);

      pipe_vld[0] <= issue;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
      end

      if (capture) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- datapath storage (qualified by valid bits) ----------------
  always_ff @(posedge clk) begin
    pipe_idx[0] <= IDX_W'(issue_cnt);
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_idx[k] <= pipe_idx[k-1];
    end
    if (capture) begin
      fifo_dat[wr_ptr] <= data_in;
      fifo_idx[wr_ptr] <= pipe_idx[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_maxpool_result_reader.sv
module tb_maxpool_result_reader;

  localparam int DW  = 27;
  localparam int AW  = 10;
  localparam int VEC = 50;

  logic          clk;
  logic          reset;
  logic          run;
  logic [AW-1:0] base_addr_in;
  logic [AW-1:0] read_address_out;
  logic [DW-1:0] data_in;
  logic [DW-1:0] vec_data_out;
  logic [5:0]    vec_index_out;
  logic          vec_valid_out;
  logic          vec_ready_in;
  logic          busy_out;
  logic          done_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] mem_q;

  maxpool_result_reader dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .base_addr_in     (base_addr_in),
    .read_address_out (read_address_out),
    .data_in          (data_in),
    .vec_data_out     (vec_data_out),
    .vec_index_out    (vec_index_out),
    .vec_valid_out    (vec_valid_out),
    .vec_ready_in     (vec_ready_in),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M10K model: registered address in the DUT plus one internal stage here.
  always @(posedge clk) mem_q <= mem[read_address_out];
  assign data_in = mem_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: ready always high; 1: ready low cycles 4..20; 2: ready toggles 1,0,1,0
  // rerun_c: cycle to pulse run again with base 500 (-1 = never)
  // rst_c  : cycle to assert reset mid-frame (-1 = never)
  task automatic run_frame(input int base, input int mode, input int rerun_c, input int rst_c);
    int   got;
    int   last_c;
    int   first_c;
    bit   fin;
    logic rdy;
    got = 0; last_c = -10; first_c = -1; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      run          = (c == 0) || (c == rerun_c);
      base_addr_in = (c == rerun_c) ? AW'(500) : AW'(base);
      reset        = (c == rst_c);
      case (mode)
        1:       rdy = !(c >= 4 && c <= 20);
        2:       rdy = (c % 2 == 0);
        default: rdy = 1'b1;
      endcase
      vec_ready_in = rdy;
      if (rst_c >= 0 && c > rst_c) begin
        if (c == rst_c + 1) begin
          check("rst_valid", vec_valid_out, 0);
          check("rst_busy", busy_out, 0);
          check("rst_done", done_out, 0);
          check("rst_addr", read_address_out, 0);
          check("rst_data", vec_data_out, 0);
          check("rst_index", vec_index_out, 0);
        end else begin
          check("post_rst_valid", vec_valid_out, 0);
          check("post_rst_done", done_out, 0);
          check("post_rst_busy", busy_out, 0);
        end
        if (c == rst_c + 12) fin = 1;
      end else begin
        check("done", done_out, (got == VEC) && (c == last_c + 1));
        check("busy", busy_out, (c >= 1) && !((got == VEC) && (c > last_c + 1)));
        if (mode == 1 && c >= 5 && c <= 20) begin
          check("stall_valid", vec_valid_out, 1);
          check("stall_data", vec_data_out, 100);
          check("stall_index", vec_index_out, 0);
          if (c == 20) check("stall_addr_held", read_address_out, 3);
        end
        if (vec_valid_out && rdy) begin
          check("index", vec_index_out, got);
          check("data", vec_data_out, ((base + got) % 1024) + 100);
          if (got == 0) first_c = c;
          got++;
          last_c = c;
        end
        if (got == VEC && c == last_c + 2) fin = 1;
      end
    end
    run   = 1'b0;
    reset = 1'b0;
    check("frame_finished", fin, 1);
    if (mode == 0 && rst_c < 0) begin
      check("first_xfer_cycle", first_c, 4);
      check("last_xfer_cycle", last_c, 53);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a + 100);
    reset        = 1'b1;
    run          = 1'b0;
    base_addr_in = '0;
    vec_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", vec_valid_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_done", done_out, 0);
    check("reset_addr", read_address_out, 0);
    check("reset_data", vec_data_out, 0);
    check("reset_index", vec_index_out, 0);
    reset = 1'b0;

    run_frame(0, 0, -1, -1);     // nominal timing
    run_frame(0, 1, -1, -1);     // long stall
    run_frame(0, 2, -1, -1);     // alternating ready
    run_frame(1020, 0, -1, -1);  // address wrap
    check("wrap_last_addr", read_address_out, 45);
    run_frame(0, 0, 10, -1);     // run during READ ignored
    run_frame(200, 0, -1, -1);   // fresh frame after done, new base
    run_frame(0, 0, -1, 15);     // reset mid-frame
    run_frame(0, 0, -1, -1);     // clean frame after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
